countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 132 +++++++++++++
 tb/tb_countdown_timer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with a programmable prescaler, one-shot or
//   periodic operation, a one-cycle terminal-count pulse and a sticky
//   interrupt flag.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   load         load count/reload/prescale/mode and arm the timer
//   load_value   start and reload count (sampled with load)
//   prescale     prescale divisor, a tick every prescale+1 enabled cycles
//   auto_reload  1 = periodic, 0 = one-shot (sampled with load)
//   enable       advances the prescaler and counter while running
//   stop         aborts a running countdown, count is held
//   irq_clear    clears the sticky interrupt
//   count        current count (registered)
//   busy         high while the timer is running
//   tc           one-cycle terminal-count pulse (registered)
//   irq          sticky interrupt, set by tc (registered)

module countdown_timer #(
    parameter int NUM_BITS      = 8,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [NUM_BITS-1:0]      load_value,
    input  logic [PRESCALE_BITS-1:0] prescale,
    input  logic                     auto_reload,
    input  logic                     enable,
    input  logic                     stop,
    input  logic                     irq_clear,
    output logic [NUM_BITS-1:0]      count,
    output logic                     busy,
    output logic                     tc,
    output logic                     irq
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   state_q,        state_d;
    logic [NUM_BITS-1:0]      count_q,        count_d;
    logic [NUM_BITS-1:0]      reload_q,       reload_d;
    logic [PRESCALE_BITS-1:0] prescale_q,     prescale_d;
    logic [PRESCALE_BITS-1:0] pcnt_q,         pcnt_d;
    logic                     mode_q,         mode_d;
    logic                     tc_q,           tc_d;
    logic                     irq_q,          irq_d;

    // Unsigned decrement that sticks at zero instead of wrapping.
    function automatic logic [NUM_BITS-1:0] dec_sat(input logic [NUM_BITS-1:0] v);
        return (v == '0) ? '0 : v - NUM_BITS'(1);
    endfunction

    // Next-state and next-register logic. Priority: load, stop, tick
    // (reset is applied in the register process).
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        mode_d     = mode_q;
        tc_d       = 1'b0;

        if (load) begin
            count_d    = load_value;
            reload_d   = load_value;
            prescale_d = prescale;
            mode_d     = auto_reload;
            pcnt_d     = '0;
            // A zero load has nothing to count, so it never arms.
            state_d    = (load_value != '0) ? S_RUN : S_IDLE;
        end else if (state_q == S_RUN) begin
            if (stop) begin
                state_d = S_IDLE;
            end else if (enable) begin
                if (pcnt_q == prescale_q) begin
                    pcnt_d = '0;
                    if (count_q == NUM_BITS'(1)) begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        count_d = dec_sat(count_q);
                    end
                end else begin
                    pcnt_d = pcnt_q + PRESCALE_BITS'(1);
                end
            end
        end

        // Setting by a terminal tick overrides a simultaneous clear.
        irq_d = tc_d | (irq_q & ~irq_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            mode_q     <= 1'b0;
            tc_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            mode_q     <= mode_d;
            tc_q       <= tc_d;
            irq_q      <= irq_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign tc    = tc_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed scenarios followed by randomized stimulus, every cycle compared
//   against a behavioural model that tracks the number of enabled cycles
//   remaining until the next tick.

module tb_countdown_timer;

    localparam int NB = 8;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [NB-1:0] load_value = '0;
    logic [PB-1:0] prescale = '0;
    logic          auto_reload = 1'b0;
    logic          enable = 1'b0;
    logic          stop = 1'b0;
    logic          irq_clear = 1'b0;
    logic [NB-1:0] count;
    logic          busy;
    logic          tc;
    logic          irq;

    countdown_timer #(.NUM_BITS(NB), .PRESCALE_BITS(PB)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_value  (load_value),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .enable      (enable),
        .stop        (stop),
        .irq_clear   (irq_clear),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_count   = 0;
    int m_reload  = 0;
    int m_pre     = 0;
    int m_mode    = 0;
    int m_left    = 1;
    int m_running = 0;
    int m_tc      = 0;
    int m_irq     = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_count = 0; m_reload = 0; m_pre = 0; m_mode = 0;
            m_left = 1; m_running = 0; m_tc = 0; m_irq = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_count   = int'(load_value);
                m_reload  = int'(load_value);
                m_pre     = int'(prescale);
                m_mode    = int'(auto_reload);
                m_left    = m_pre + 1;
                m_running = (m_count != 0) ? 1 : 0;
            end else if (m_running == 1 && stop) begin
                m_running = 0;
            end else if (m_running == 1 && enable) begin
                m_left--;
                if (m_left == 0) begin
                    m_left = m_pre + 1;
                    if (m_count > 1) begin
                        m_count--;
                    end else begin
                        m_tc = 1;
                        if (m_mode == 1) m_count = m_reload;
                        else begin
                            m_count   = 0;
                            m_running = 0;
                        end
                    end
                end
            end
            if (m_tc == 1) m_irq = 1;
            else if (irq_clear) m_irq = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("count", int'(count), m_count);
        chk("busy",  int'(busy),  m_running);
        chk("tc",    int'(tc),    m_tc);
        chk("irq",   int'(irq),   m_irq);
    endtask

    task automatic quiet();
        rst = 1'b0; load = 1'b0; stop = 1'b0; irq_clear = 1'b0;
    endtask

    task automatic do_load(input int lv, input int ps, input bit ar);
        load_value  = NB'(lv);
        prescale    = PB'(ps);
        auto_reload = ar;
        load        = 1'b1;
        step();
        load        = 1'b0;
    endtask

    // Steps until tc is seen; n is the number of edges taken (maxc if none).
    task automatic cycles_to_tc(input int maxc, output int n);
        n = maxc;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (tc) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int en_cnt;

    initial begin
        // Reset
        quiet();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);

        // One-shot countdown of 3
        enable = 1'b1;
        do_load(3, 0, 1'b0);
        chk("oneshot_first", int'(count), 3);
        step(); step(); step();
        chk("oneshot_tc", int'(tc), 1);
        chk("oneshot_busy_falls", int'(busy), 0);
        step(); step();
        chk("oneshot_irq_sticky", int'(irq), 1);

        // Prescale 2 with a pause in the middle
        do_load(2, 2, 1'b0);
        en_cnt = 2;
        step(); step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pause_hold", int'(count), 2);
        enable = 1'b1;
        cycles_to_tc(20, n);
        chk("prescale_enabled_cycles", en_cnt + n, 6);

        // Periodic, then stop, then load beating stop
        do_load(2, 0, 1'b1);
        for (int i = 0; i < 6; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        step(); step();
        stop = 1'b1;
        do_load(2, 0, 1'b1);
        stop = 1'b0;
        chk("load_beats_stop", int'(busy), 1);
        step(); step(); step();

        // Zero load
        do_load(0, 0, 1'b0);
        chk("zero_load_busy", int'(busy), 0);
        step(); step(); step();

        // Full-scale count
        do_load(255, 0, 1'b0);
        cycles_to_tc(300, n);
        chk("latency_255", n, 255);

        // Full-scale prescale
        do_load(2, 15, 1'b0);
        cycles_to_tc(100, n);
        chk("latency_pre15", n, 32);

        // irq clear timing
        irq_clear = 1'b1;
        step();
        chk("irq_cleared", int'(irq), 0);
        irq_clear = 1'b0;
        do_load(1, 0, 1'b0);
        irq_clear = 1'b1;
        step();
        chk("irq_set_wins", int'(irq), 1);
        step();
        chk("irq_clear_later", int'(irq), 0);
        irq_clear = 1'b0;

        // Reset mid-run, then immediate reload
        do_load(5, 0, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_count", int'(count), 0);
        chk("midrun_rst_busy", int'(busy), 0);
        do_load(1, 0, 1'b0);
        cycles_to_tc(5, n);
        chk("post_rst_latency", n, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            load        = ($urandom_range(0, 29) == 0);
            load_value  = ($urandom_range(0, 9) == 0) ? NB'($urandom_range(0, 255))
                                                       : NB'($urandom_range(0, 5));
            prescale    = ($urandom_range(0, 7) == 0) ? PB'(15) : PB'($urandom_range(0, 2));
            auto_reload = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 4) != 0);
            stop        = ($urandom_range(0, 59) == 0);
            irq_clear   = ($urandom_range(0, 7) == 0);
            step();
        end
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
